// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Sequential instruction fetcher. It issues word-aligned reads to an
//   in-order instruction memory and places the returned words in a 2-entry
//   {pc, instr} buffer. It presents the head of that buffer to the core.
//   A redirect flushes the buffer. It also discards every response that was
//   still in flight when the redirect arrived.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   enable                allows new memory requests
//   redirect, redirect_pc one-cycle retarget pulse and its (re-aligned) target
//   mem_req, mem_addr     request to instruction memory
//   mem_gnt               memory accepts request (mem_req && mem_gnt)
//   mem_rvalid, mem_rdata in-order read response, latency >= 1
//   instr_valid           head entry available
//   instruction, instr_pc head entry word / address (NOP + last pc if empty)
//   instr_ready           core pops head (instr_valid && instr_ready)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  // Address of the next response that will be kept. Every kept response
  // follows the previous one by 4 bytes. A redirect restarts this address
  // at the redirect target, so one register is enough to track it.
  logic [31:0] resp_pc_reg, resp_pc_next;
  logic [31:0] held_pc_reg;
  logic [1:0]  outstanding_reg, outstanding_next;
  logic [1:0]  discard_reg, discard_next;
  logic [1:0]  count_reg, count_next;
  logic        head_reg, tail_reg;

  logic        credit_ok, accept, rsp, push, pop;
  logic [31:0] redirect_target, head_pc, head_instr;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // A request is allowed only if the buffer has room for every response it
  // could produce. The count includes responses already in flight.
  assign credit_ok = (3'(outstanding_reg) + 3'(count_reg)) < 3'd2;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    if (redirect) begin
      if (outstanding_next != 2'd0) state_next = DRAIN;
      else                          state_next = enable ? FETCH : IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (enable)  state_next = FETCH;
        FETCH:   if (!enable) state_next = IDLE;
        DRAIN:   if (discard_next == 2'd0) state_next = enable ? FETCH : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mem_req  = (state_reg == FETCH) && !redirect && credit_ok;
    mem_addr = fetch_pc_reg;
  end

  assign accept = mem_req && mem_gnt;
  // A response that arrives with nothing in flight is spurious and is ignored.
  assign rsp    = mem_rvalid && (outstanding_reg != 2'd0);
  assign push   = rsp && !redirect && (discard_reg == 2'd0);
  assign pop    = instr_valid && instr_ready && !redirect;

  assign outstanding_next = outstanding_reg + {1'b0, accept} - {1'b0, rsp};

  always_comb begin
    discard_next = discard_reg;
    if (redirect)                          discard_next = outstanding_next;
    else if (rsp && discard_reg != 2'd0)   discard_next = discard_reg - 2'd1;
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;
    if (redirect) begin
      fetch_pc_next = redirect_target;
      resp_pc_next  = redirect_target;
    end else begin
      if (accept) fetch_pc_next = fetch_pc_reg + 32'd4;
      if (push)   resp_pc_next  = resp_pc_reg + 32'd4;
    end
  end

  assign count_next = redirect ? 2'd0 : (count_reg + {1'b0, push} - {1'b0, pop});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      held_pc_reg     <= RESET_PC;
      outstanding_reg <= 2'd0;
      discard_reg     <= 2'd0;
      count_reg       <= 2'd0;
      head_reg        <= 1'b0;
      tail_reg        <= 1'b0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      held_pc_reg     <= instr_pc;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      count_reg       <= count_next;
      if (redirect) begin
        head_reg <= 1'b0;
        tail_reg <= 1'b0;
      end else begin
        if (push) tail_reg <= ~tail_reg;
        if (pop)  head_reg <= ~head_reg;
      end
    end
  end

  // Buffer storage: one register pair per slot.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      localparam logic SLOT = 1'(gi);
      logic [31:0] pc_reg;
      logic [31:0] instr_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pc_reg    <= RESET_PC;
          instr_reg <= NOP_INSTR;
        end else if (push && (tail_reg == SLOT)) begin
          pc_reg    <= resp_pc_reg;
          instr_reg <= mem_rdata;
        end
      end
    end
  endgenerate

  assign head_pc    = head_reg ? g_entry[1].pc_reg    : g_entry[0].pc_reg;
  assign head_instr = head_reg ? g_entry[1].instr_reg : g_entry[0].instr_reg;

  // The outputs depend only on registers. mem_rdata first has to pass
  // through a buffer slot before it can reach them.
  assign instr_valid = (count_reg != 2'd0);
  assign instruction = instr_valid ? head_instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head_pc    : held_pc_reg;

endmodule
